// File: rtl/dds_word_tx.sv
// dds_word_tx: serializes a DATA_W-bit DDS tuning word MSB first, launched on the falling edge of a forwarded 10 MHz bit clock.
// Define DDS_WORD_TX_PARITY_EN to append one even-parity bit to each frame.
module dds_word_tx #(
  parameter int DATA_W    = 32,
  parameter int GAP_TICKS = 2
) (
  input  logic              FiftyMHz_ref_clock,
  input  logic              reset_n,
  input  logic              TenMHz_clock,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              serial_clk,
  output logic              serial_data,
  output logic              serial_frame,
  output logic              tx_done
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int GAP_W = (GAP_TICKS < 1) ? 1 : $clog2(GAP_TICKS + 1);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_TICKS);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ARMED  = 3'd1;
  localparam logic [2:0] S_SHIFT  = 3'd2;
  localparam logic [2:0] S_GAP    = 3'd3;
`ifdef DDS_WORD_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd4;
`endif

  logic [2:0]        state_q,   state_d;
  logic [DATA_W-1:0] shift_q,   shift_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic              data_q,    data_d;
  logic              frame_q,   frame_d;
  logic              done_q,    done_d;
  logic              ten_clk_q;
  logic              tick;
  logic              end_frame;
`ifdef DDS_WORD_TX_PARITY_EN
  logic              parity_q,  parity_d;
`endif

  // Falling edge of the bit clock: the receiver samples on the following rising edge.
  assign tick = ten_clk_q & ~TenMHz_clock;

  assign tx_ready     = (state_q == S_IDLE);
  assign serial_clk   = ten_clk_q;
  assign serial_data  = data_q;
  assign serial_frame = frame_q;
  assign tx_done      = done_q;

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    data_d    = data_q;
    frame_d   = frame_q;
    done_d    = 1'b0;
    end_frame = 1'b0;
`ifdef DDS_WORD_TX_PARITY_EN
    parity_d  = parity_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (tx_valid) begin
          shift_d   = tx_data;
          bit_cnt_d = '0;
          state_d   = S_ARMED;
`ifdef DDS_WORD_TX_PARITY_EN
          parity_d  = ^tx_data;
`endif
        end
      end

      S_ARMED: begin
        if (tick) begin
          frame_d   = 1'b1;
          data_d    = shift_q[DATA_W-1];
          shift_d   = shift_q << 1;
          bit_cnt_d = CNT_W'(1);
          state_d   = S_SHIFT;
        end
      end

      // bit_cnt_q counts bits already on the line, so LAST_BIT means bit 0 has had its full period.
      S_SHIFT: begin
        if (tick) begin
          if (bit_cnt_q == LAST_BIT) begin
`ifdef DDS_WORD_TX_PARITY_EN
            data_d  = parity_q;
            state_d = S_PARITY;
`else
            end_frame = 1'b1;
`endif
          end else begin
            data_d    = shift_q[DATA_W-1];
            shift_d   = shift_q << 1;
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end

`ifdef DDS_WORD_TX_PARITY_EN
      S_PARITY: begin
        if (tick) begin
          end_frame = 1'b1;
        end
      end
`endif

      S_GAP: begin
        if (tick) begin
          if (gap_cnt_q == GAP_ONE) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            gap_cnt_d = gap_cnt_q - 1'b1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    // With no gap configured the frame-ending tick completes the word directly.
    if (end_frame) begin
      frame_d   = 1'b0;
      data_d    = 1'b0;
      bit_cnt_d = '0;
      if (GAP_TICKS == 0) begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end else begin
        state_d   = S_GAP;
        gap_cnt_d = GAP_LOAD;
      end
    end
  end

  always_ff @(posedge FiftyMHz_ref_clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      data_q    <= 1'b0;
      frame_q   <= 1'b0;
      done_q    <= 1'b0;
      ten_clk_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      data_q    <= data_d;
      frame_q   <= frame_d;
      done_q    <= done_d;
      ten_clk_q <= TenMHz_clock;
    end
  end

`ifdef DDS_WORD_TX_PARITY_EN
  always_ff @(posedge FiftyMHz_ref_clock or negedge reset_n) begin
    if (!reset_n) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end
`endif

endmodule

// File: tb/tb_dds_word_tx.sv
// tb_dds_word_tx: self-checking bench for dds_word_tx with a frame-level reference model and scoreboard.
module tb_dds_word_tx;

  localparam int DW  = 32;
  localparam int GAP = 2;
`ifdef DDS_WORD_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FLEN = DW + PAR;

  logic          clk    = 1'b0;
  logic          rstN   = 1'b0;
  logic          tenClk = 1'b0;
  int            phase  = 0;

  logic [DW-1:0] txData   = '0;
  logic          txValid  = 1'b0;
  logic [DW-1:0] txData0  = '0;
  logic          txValid0 = 1'b0;
  logic          txReady,  serClk,  serData,  serFrame,  txDone;
  logic          txReady0, serClk0, serData0, serFrame0, txDone0;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic [FLEN-1:0] bits;
    int              nBits;
    int              nCycles;
    int              gapTicks;
  } frame_t;

  typedef struct {
    logic [DW-1:0] data;
    logic          expPar;
  } vec_t;

  frame_t          seen[$];
  logic [FLEN-1:0] expQ[$];

  dds_word_tx #(.DATA_W(DW), .GAP_TICKS(GAP)) dut (
    .FiftyMHz_ref_clock(clk), .reset_n(rstN), .TenMHz_clock(tenClk),
    .tx_data(txData), .tx_valid(txValid), .tx_ready(txReady),
    .serial_clk(serClk), .serial_data(serData), .serial_frame(serFrame), .tx_done(txDone));

  dds_word_tx #(.DATA_W(DW), .GAP_TICKS(0)) dut0 (
    .FiftyMHz_ref_clock(clk), .reset_n(rstN), .TenMHz_clock(tenClk),
    .tx_data(txData0), .tx_valid(txValid0), .tx_ready(txReady0),
    .serial_clk(serClk0), .serial_data(serData0), .serial_frame(serFrame0), .tx_done(txDone0));

  always #10 clk = ~clk;

  // 10 MHz, 40% duty divider synchronous to the 50 MHz reference.
  always @(posedge clk) begin
    phase  <= (phase == 4) ? 0 : phase + 1;
    tenClk <= (phase == 4) || (phase == 0);
  end

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails + 1);
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic logic modelParity(input logic [DW-1:0] w);
    int ones = 0;
    for (int i = 0; i < DW; i++) ones += int'(w[i]);
    return (ones % 2) == 1;
  endfunction

  // The line carries the word MSB first, optionally followed by its even parity.
  function automatic logic [FLEN-1:0] modelFrame(input logic [DW-1:0] w);
    logic [FLEN-1:0] f;
    f = '0;
    for (int i = 0; i < DW; i++) f[FLEN-1-i] = w[DW-1-i];
    if (PAR == 1) f[0] = modelParity(w);
    return f;
  endfunction

  function automatic logic [FLEN-1:0] tableFrame(input logic [DW-1:0] w, input logic p);
    if (PAR == 1) return FLEN'({w, p});
    return FLEN'(w);
  endfunction

  // Line monitor: collects bits on serial_clk rises while framed, then gap ticks until tx_done.
  logic            prevSerClk = 1'b0;
  logic            prevFrame  = 1'b0;
  logic            prevDone   = 1'b0;
  logic            inGap      = 1'b0;
  logic [FLEN-1:0] curBits    = '0;
  int              curN = 0, curCyc = 0, curGap = 0;

  always @(negedge clk) begin
    if (!rstN) begin
      curN = 0; curCyc = 0; curGap = 0; inGap = 1'b0;
      prevFrame = 1'b0; prevDone = 1'b0;
    end else begin
      if (serFrame) begin
        curCyc++;
        if (serClk && !prevSerClk) begin
          if (curN < FLEN) curBits[FLEN-1-curN] = serData;
          curN++;
        end
      end
      if (prevFrame && !serFrame) begin
        inGap = 1'b1;
        curGap = 0;
      end else if (inGap && serClk && !prevSerClk) begin
        curGap++;
      end
      if (txDone) begin
        checkOutput("done_with_ready", txReady, 1);
        checkOutput("done_single_cycle", prevDone, 0);
        checkOutput("done_after_frame", inGap, 1);
        seen.push_back('{bits: curBits, nBits: curN, nCycles: curCyc, gapTicks: curGap});
        inGap = 1'b0; curN = 0; curCyc = 0; curBits = '0;
      end
      prevFrame = serFrame;
      prevDone  = txDone;
    end
    prevSerClk = serClk;
  end

  task automatic applyStimulus(input logic [DW-1:0] word);
    int n = 0;
    while (!txReady && n < 1000) begin @(negedge clk); n++; end
    if (!txReady) checkOutput("ready_timeout", 0, 1);
    txValid = 1'b1;
    txData  = word;
    @(negedge clk);
    txValid = 1'b0;
    txData  = $urandom;
  endtask

  task automatic drainFrames();
    int n = 0;
    while (seen.size() < expQ.size() && n < 400 * (expQ.size() + 1)) begin @(negedge clk); n++; end
    while (expQ.size() > 0) begin
      logic [FLEN-1:0] e;
      frame_t f;
      e = expQ.pop_front();
      if (seen.size() == 0) begin
        checkOutput("frame_missing", 0, 1);
      end else begin
        f = seen.pop_front();
        checkOutput("frame_bits", 64'(f.bits), 64'(e));
        checkOutput("frame_ticks", f.nBits, FLEN);
        checkOutput("frame_cycles", f.nCycles, 5 * FLEN);
        checkOutput("gap_ticks", f.gapTicks, GAP);
      end
    end
    checkOutput("no_extra_frames", seen.size(), 0);
  endtask

  task automatic collect0(output logic [FLEN-1:0] bits, output int cyc);
    logic prev;
    int   k = 0;
    bits = '0; cyc = 0; prev = serClk0;
    while (serFrame0 && cyc < 10 * FLEN) begin
      cyc++;
      if (serClk0 && !prev) begin
        if (k < FLEN) bits[FLEN-1-k] = serData0;
        k++;
      end
      prev = serClk0;
      @(negedge clk);
    end
  endtask

  vec_t vecs[7];

  initial begin
    logic [DW-1:0] w;
    int n;
    int rises;
    logic bad;
    logic [FLEN-1:0] b0;
    int c0;

    vecs[0] = '{32'hA5A5_0F0F, 1'b0};
    vecs[1] = '{32'h0000_0001, 1'b1};
    vecs[2] = '{32'h0000_0003, 1'b0};
    vecs[3] = '{32'hFFFF_FFFF, 1'b0};
    vecs[4] = '{32'h8000_0000, 1'b1};
    vecs[5] = '{32'h0000_0000, 1'b0};
    vecs[6] = '{32'hDEAD_BEEF, 1'b0};

    // Reset state, with a request pending that must not be taken.
    txValid = 1'b1; txData = 32'h1234_5678;
    repeat (4) @(negedge clk);
    checkOutput("rst_ready", txReady, 1);
    checkOutput("rst_frame", serFrame, 0);
    checkOutput("rst_data", serData, 0);
    checkOutput("rst_serclk", serClk, 0);
    checkOutput("rst_done", txDone, 0);
    txValid = 1'b0;
    @(negedge clk);
    rstN = 1'b1;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].data);
      expQ.push_back(tableFrame(vecs[i].data, vecs[i].expPar));
      drainFrames();
    end

    for (int i = 0; i < 6; i++) begin
      w = $urandom;
      applyStimulus(w);
      expQ.push_back(modelFrame(w));
      drainFrames();
    end

    // Request arriving in a tick cycle launches on the next tick, five cycles on.
    n = 0;
    while (!(txReady && serClk && !tenClk) && n < 20) begin @(negedge clk); n++; end
    checkOutput("tick_found", txReady && serClk && !tenClk, 1);
    txValid = 1'b1; txData = 32'h5A5A_C3C3;
    @(negedge clk);
    txValid = 1'b0; txData = $urandom;
    repeat (4) @(negedge clk);
    checkOutput("no_launch_early", serFrame, 0);
    @(negedge clk);
    checkOutput("launch_next_tick", serFrame, 1);
    expQ.push_back(modelFrame(32'h5A5A_C3C3));
    drainFrames();

    // tx_valid held high across two words.
    fork
      begin
        txValid = 1'b1; txData = 32'h1111_1111;
        n = 0;
        while (!txReady && n < 100) begin @(negedge clk); n++; end
        @(negedge clk);
        txData = 32'h2222_2222;
        n = 0;
        while (!txReady && n < 500) begin @(negedge clk); n++; end
        @(negedge clk);
        txValid = 1'b0;
      end
      begin
        int m = 0;
        while (!txDone && m < 500) begin @(negedge clk); m++; end
        checkOutput("b2b_done_seen", txDone, 1);
        m = 0;
        while (!serFrame && m < 20) begin @(negedge clk); m++; end
        checkOutput("b2b_relaunch_cycles", m, 5);
      end
    join
    expQ.push_back(modelFrame(32'h1111_1111));
    expQ.push_back(modelFrame(32'h2222_2222));
    drainFrames();

    // Asynchronous reset ten bits into a frame.
    applyStimulus(32'hFFFF_FFFF);
    rises = 0; n = 0;
    while (rises < 10 && n < 200) begin
      @(negedge clk); n++;
      if (serFrame && serClk && !prevSerClk) rises++;
    end
    checkOutput("midframe_active", serFrame, 1);
    checkOutput("midframe_data", serData, 1);
    #3 rstN = 1'b0;
    #1;
    checkOutput("async_rst_frame", serFrame, 0);
    checkOutput("async_rst_data", serData, 0);
    checkOutput("async_rst_serclk", serClk, 0);
    checkOutput("async_rst_ready", txReady, 1);
    checkOutput("async_rst_done", txDone, 0);
    repeat (3) @(negedge clk);
    rstN = 1'b1;
    bad = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (txDone || serFrame || !txReady) bad = 1'b1;
    end
    checkOutput("post_rst_quiet", bad, 0);
    checkOutput("post_rst_no_frame", seen.size(), 0);

    // Zero-gap instance, back-to-back words.
    fork
      begin
        txValid0 = 1'b1; txData0 = 32'hCAFE_F00D;
        n = 0;
        while (!txReady0 && n < 100) begin @(negedge clk); n++; end
        @(negedge clk);
        txData0 = 32'h0BAD_BEEF;
        n = 0;
        while (!txReady0 && n < 500) begin @(negedge clk); n++; end
        @(negedge clk);
        txValid0 = 1'b0;
      end
      begin
        int m = 0;
        while (!serFrame0 && m < 20) begin @(negedge clk); m++; end
        collect0(b0, c0);
        checkOutput("g0_frame1_bits", 64'(b0), 64'(modelFrame(32'hCAFE_F00D)));
        checkOutput("g0_frame1_cycles", c0, 5 * FLEN);
        checkOutput("g0_done_next_cycle", txDone0, 1);
        checkOutput("g0_ready_with_done", txReady0, 1);
        m = 0;
        while (!serFrame0 && m < 20) begin @(negedge clk); m++; end
        checkOutput("g0_relaunch_cycles", m, 5);
        collect0(b0, c0);
        checkOutput("g0_frame2_bits", 64'(b0), 64'(modelFrame(32'h0BAD_BEEF)));
        checkOutput("g0_done2", txDone0, 1);
      end
    join
    repeat (20) @(negedge clk);
    checkOutput("g0_idle_after", serFrame0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
